// File: rtl/snoop_pkg.sv
// snoop_pkg: opcodes, node IDs and FSM state shared by the snoop filter and dispatcher
package snoop_pkg;
  localparam logic [6:0] READ_SHARED = 7'b0000001;
  localparam logic [6:0] READ_UNIQUE = 7'b0000111;
  localparam logic [6:0] WRITE_BACK_FULL = 7'b0011011;
  localparam logic [6:0] NID_RN1 = 7'b0000001;
  localparam logic [6:0] NID_RN2 = 7'b0000010;
  localparam logic [6:0] NID_RN3 = 7'b0000100;
  localparam logic [6:0] NID_RN4 = 7'b0001000;
  localparam logic [6:0] SNP_SHARED = 7'h01;
  localparam logic [6:0] SNP_UNIQUE = 7'h07;
  typedef enum logic [1:0] {IDLE, SNOOP, DONE} snp_state_t;
  function automatic logic snoopable(input logic [6:0] op);
    return op == READ_SHARED || op == READ_UNIQUE;
  endfunction
endpackage

// File: rtl/snoop_channel.sv
// snoop_channel: per-RN issue/wait tracking, snoop handshake and response qualification
module snoop_channel (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic load,
  input  logic target,
  input  logic abort,
  input  logic snp_ready,
  input  logic rsp_valid,
  input  logic rsp_dirty,
  output logic snp_valid,
  output logic pending,
  output logic accepted,
  output logic dirty,
  output logic stray
);
  logic issue, waiting, hs;
  always_comb begin
    hs = active & issue & snp_ready;
    snp_valid = active & issue;
    accepted = active & waiting & rsp_valid;
    stray = active & rsp_valid & ~waiting;
    dirty = accepted & rsp_dirty;
    // pending ignores abort so the top can derive abort from it without a loop
    pending = (issue & ~hs) | ((waiting | hs) & ~accepted);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      issue <= 1'b0;
      waiting <= 1'b0;
    end else begin
      issue <= load ? target : issue & ~hs & ~abort;
      waiting <= ~load & ~abort & (waiting | hs) & ~accepted;
    end
endmodule

// File: rtl/snoop_dispatcher.sv
// snoop_dispatcher: issues snoops to the RNs flagged by the filter, gathers responses,
// and reports one completion per request.
module snoop_dispatcher
  import snoop_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int P = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_tag,
  input  logic [6:0]       req_opcode,
  input  logic [6:0]       req_nid,
  input  logic [P-1:0]     req_targets,
  output logic [P-1:0]     snp_valid,
  input  logic [P-1:0]     snp_ready,
  output logic [WIDTH-1:0] snp_tag,
  output logic [6:0]       snp_opcode,
  input  logic [P-1:0]     rsp_valid,
  input  logic [P-1:0]     rsp_dirty,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] done_tag,
  output logic             done_dirty,
  output logic             done_err,
  output logic [P-1:0]     done_resp_mask
);
  localparam int CW = $clog2(TIMEOUT);
  snp_state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [P-1:0] issue_mask, pend, acc, dirt, stray;
  logic accept, active, tmo, settled, abort, unused_nid;
  assign unused_nid = ^req_nid[6:P];
  assign done_tag = snp_tag;
  always_comb begin
    req_ready = state == IDLE;
    active = state == SNOOP;
    done_valid = state == DONE;
    accept = req_valid & req_ready;
    issue_mask = snoopable(req_opcode) ? req_targets & ~req_nid[P-1:0] : '0;
    tmo = cnt == CW'(TIMEOUT - 1);
    settled = ~|pend;
    abort = active & tmo & ~settled;
    state_nxt = state;
    if (accept) state_nxt = |issue_mask ? SNOOP : DONE;
    else if (active && (settled || tmo)) state_nxt = DONE;
    else if (done_valid && done_ready) state_nxt = IDLE;
  end
  for (genvar i = 0; i < P; i++) begin : g_ch
    snoop_channel u_ch (
      .clk(clk),
      .reset(reset),
      .active(active),
      .load(accept),
      .target(issue_mask[i]),
      .abort(abort),
      .snp_ready(snp_ready[i]),
      .rsp_valid(rsp_valid[i]),
      .rsp_dirty(rsp_dirty[i]),
      .snp_valid(snp_valid[i]),
      .pending(pend[i]),
      .accepted(acc[i]),
      .dirty(dirt[i]),
      .stray(stray[i])
    );
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      snp_tag <= '0;
      snp_opcode <= '0;
      done_dirty <= 1'b0;
      done_err <= 1'b0;
      done_resp_mask <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        snp_tag <= req_tag;
        snp_opcode <= req_opcode == READ_UNIQUE ? SNP_UNIQUE : SNP_SHARED;
        cnt <= '0;
        done_dirty <= 1'b0;
        done_err <= 1'b0;
        done_resp_mask <= '0;
      end else if (active) begin
        cnt <= cnt + CW'(!tmo);
        done_dirty <= done_dirty | |dirt;
        done_resp_mask <= done_resp_mask | acc;
        done_err <= done_err | |stray | abort;
      end
    end
endmodule

// File: tb/tb_snoop_dispatcher.sv
// tb_snoop_dispatcher: directed bench for snoop_dispatcher
module tb_snoop_dispatcher;
  import snoop_pkg::*;
  localparam int WIDTH = 33;
  localparam int P = 4;
  logic clk = 0, reset = 0;
  logic req_valid = 0, done_ready = 0;
  logic req_ready, done_valid, done_dirty, done_err;
  logic [WIDTH-1:0] req_tag = '0, snp_tag, done_tag;
  logic [6:0] req_opcode = '0, req_nid = '0, snp_opcode;
  logic [P-1:0] req_targets = '0, snp_valid, snp_ready = 4'b1111;
  logic [P-1:0] rsp_valid = '0, rsp_dirty = '0, done_resp_mask;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  snoop_dispatcher dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_opcode(req_opcode), .req_nid(req_nid), .req_targets(req_targets),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_tag(snp_tag), .snp_opcode(snp_opcode),
    .rsp_valid(rsp_valid), .rsp_dirty(rsp_dirty), .done_valid(done_valid), .done_ready(done_ready),
    .done_tag(done_tag), .done_dirty(done_dirty), .done_err(done_err), .done_resp_mask(done_resp_mask)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic send(input logic [WIDTH-1:0] t, input logic [6:0] op, input logic [6:0] nid,
                      input logic [P-1:0] tgt);
    req_valid = 1; req_tag = t; req_opcode = op; req_nid = nid; req_targets = tgt;
    check("accept_ready", req_ready, 1);
    tick();
    req_valid = 0;
  endtask
  task automatic ack();
    done_ready = 1;
    tick();
    done_ready = 0;
    check("back_to_idle", req_ready, 1);
  endtask
  initial begin
    tick(); tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_snp_valid", snp_valid, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_snp_tag", snp_tag, 0);
    check("rst_snp_opcode", snp_opcode, 0);
    check("rst_done_bits", {done_dirty, done_err, done_resp_mask}, 0);
    reset = 1;
    tick();
    // READ_SHARED from RN1 to RN2..RN4, RN3 dirty
    send(33'h1_2345_6789, READ_SHARED, NID_RN1, 4'b1110);
    check("t1_snp_valid", snp_valid, 4'b1110);
    check("t1_snp_opcode", snp_opcode, 7'h01);
    check("t1_snp_tag", snp_tag, 33'h1_2345_6789);
    check("t1_busy", req_ready, 0);
    tick();
    rsp_valid = 4'b1110; rsp_dirty = 4'b0100;
    check("t1_c2_no_done", done_valid, 0);
    tick();
    rsp_valid = 0; rsp_dirty = 0;
    check("t1_done_valid", done_valid, 1);
    check("t1_done_dirty", done_dirty, 1);
    check("t1_resp_mask", done_resp_mask, 4'b1110);
    check("t1_err", done_err, 0);
    check("t1_done_tag", done_tag, 33'h1_2345_6789);
    ack();
    // READ_UNIQUE from RN2: requester masked off
    send(33'h0_0000_00aa, READ_UNIQUE, NID_RN2, 4'b0011);
    check("t2_snp_valid", snp_valid, 4'b0001);
    check("t2_snp_opcode", snp_opcode, 7'h07);
    tick();
    rsp_valid = 4'b0001;
    tick();
    rsp_valid = 0;
    check("t2_done_valid", done_valid, 1);
    check("t2_resp_mask", done_resp_mask, 4'b0001);
    check("t2_err_dirty", {done_err, done_dirty}, 0);
    ack();
    // WRITE_BACK_FULL: no snoops, done next cycle
    send(33'h1_0000_0001, WRITE_BACK_FULL, NID_RN1, 4'b1111);
    check("t3_done_valid", done_valid, 1);
    check("t3_snp_valid", snp_valid, 0);
    check("t3_resp_mask", done_resp_mask, 0);
    check("t3_err", done_err, 0);
    ack();
    // RN3 holds snp_ready low for 5 cycles
    snp_ready = 4'b1011;
    send(33'h0_dead_beef, READ_SHARED, NID_RN1, 4'b1110);
    check("t4_c1_snp_valid", snp_valid, 4'b1110);
    tick();
    rsp_valid = 4'b1010;
    for (int k = 2; k <= 6; k++) begin
      check("t4_hold_valid", snp_valid, 4'b0100);
      check("t4_hold_tag", snp_tag, 33'h0_dead_beef);
      if (k == 6) snp_ready = 4'b1111;
      tick();
      rsp_valid = 0;
    end
    check("t4_c7_snp_valid", snp_valid, 0);
    check("t4_c7_no_done", done_valid, 0);
    rsp_valid = 4'b0100; rsp_dirty = 4'b0100;
    tick();
    rsp_valid = 0; rsp_dirty = 0;
    check("t4_done_valid", done_valid, 1);
    check("t4_resp_mask", done_resp_mask, 4'b1110);
    check("t4_dirty_err", {done_dirty, done_err}, 2'b10);
    ack();
    // RN4 never handshakes nor responds: timeout after 64 SNOOP cycles
    snp_ready = 4'b0111;
    send(33'h1_5555_aaaa, READ_SHARED, NID_RN1, 4'b1110);
    tick();
    rsp_valid = 4'b0110;
    tick();
    rsp_valid = 0;
    repeat (61) tick();
    check("t5_c64_snp_valid", snp_valid, 4'b1000);
    check("t5_c64_no_done", done_valid, 0);
    tick();
    check("t5_snp_dropped", snp_valid, 0);
    for (int k = 0; k < 4; k++) begin
      check("t5_done_valid", done_valid, 1);
      check("t5_done_err", done_err, 1);
      check("t5_resp_mask", done_resp_mask, 4'b0110);
      check("t5_done_tag", done_tag, 33'h1_5555_aaaa);
      if (k < 3) tick();
    end
    snp_ready = 4'b1111;
    ack();
    // response in the same cycle as its own handshake is an error
    send(33'h0_0000_0077, READ_SHARED, NID_RN1, 4'b0010);
    rsp_valid = 4'b0010;
    tick();
    check("t6_c2_no_done", done_valid, 0);
    tick();
    rsp_valid = 0;
    check("t6_done_valid", done_valid, 1);
    check("t6_err", done_err, 1);
    check("t6_resp_mask", done_resp_mask, 4'b0010);
    ack();
    // asynchronous reset in SNOOP
    snp_ready = 4'b0000;
    send(33'h0_1234_0000, READ_UNIQUE, NID_RN1, 4'b1110);
    check("t7_snp_valid", snp_valid, 4'b1110);
    #2 reset = 0;
    #1;
    check("t7_rst_snp_valid", snp_valid, 0);
    check("t7_rst_req_ready", req_ready, 1);
    check("t7_rst_tag_op", {snp_tag, snp_opcode}, 0);
    check("t7_rst_done", {done_valid, done_dirty, done_err, done_resp_mask}, 0);
    #1 reset = 1;
    snp_ready = 4'b1111;
    tick(); tick();
    check("t7_no_done", done_valid, 0);
    check("t7_idle", req_ready, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
